// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  // A later-stage write matches a source tag; register $0 is never a producer.
  function automatic logic tag_hit(input logic we, input logic [4:0] wr, input logic [4:0] src);
    return we && (wr != 5'd0) && (wr == src);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle; the pipeline is master, the hazard unit is slave.
interface hazard_unit_if #(parameter int STAT_W = 16);

  logic [4:0]        Rs_D, Rt_D, Rs_E, Rt_E;
  logic [4:0]        WriteReg_E, WriteReg_M, WriteReg_W;
  logic              RegWrite_E, MemToReg_E;
  logic              RegWrite_M, MemToReg_M;
  logic              RegWrite_W;
  logic              Branch_D, PCSrc_D;
  logic              MulDiv_D, MfHiLo_D, MulDivStart_E;

  logic              Stall_F, Stall_D, Flush_D, Flush_E;
  logic              ForwardA_D, ForwardB_D;
  logic [1:0]        ForwardA_E, ForwardB_E;
  logic              MdBusy;
  logic [STAT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, MemToReg_E, RegWrite_M, MemToReg_M, RegWrite_W,
           Branch_D, PCSrc_D, MulDiv_D, MfHiLo_D, MulDivStart_E,
    input  Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_D, ForwardB_D,
           ForwardA_E, ForwardB_E, MdBusy, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W,
           RegWrite_E, MemToReg_E, RegWrite_M, MemToReg_M, RegWrite_W,
           Branch_D, PCSrc_D, MulDiv_D, MfHiLo_D, MulDivStart_E,
    output Stall_F, Stall_D, Flush_D, Flush_E, ForwardA_D, ForwardB_D,
           ForwardA_E, ForwardB_E, MdBusy, StallCnt, FlushCnt
  );

endinterface

// File: rtl/hazard_unit_muldiv_busy_tracker.sv
// Tracks the HI/LO unit occupancy window: busy for exactly MD_LATENCY cycles after an issue.
module muldiv_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_busy
);

  localparam int CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  md_state_t        r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // A start while already busy cannot occur legally, so it is simply ignored.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      MD_IDLE: begin
        if (i_start) begin
          w_next_state = MD_BUSY;
          w_next_cnt   = CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_BUSY: begin
        if (r_cnt == '0) begin
          w_next_state = MD_IDLE;
        end else begin
          w_next_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_next_state = MD_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_comb begin
    o_busy = (r_state == MD_BUSY);
  end

endmodule

// File: rtl/hazard_unit.sv
// Combinational stall/flush/forward control for the 5-stage core plus the mul/div busy window.
// Optional stall/flush performance counters are enabled by defining HAZARD_STATS_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int STAT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_unit_if.slave  hz
);

  logic       w_md_busy;
  logic       w_lwstall, w_brstall, w_mdstall, w_stall, w_flush_d;
  logic [1:0] w_fwd_a_e, w_fwd_b_e;

  muldiv_busy_tracker #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (hz.MulDivStart_E),
    .o_busy  (w_md_busy)
  );

  // MEM has the newer value, so it wins over WB.
  always_comb begin
    w_fwd_a_e = FWD_RF;
    if (tag_hit(hz.RegWrite_M, hz.WriteReg_M, hz.Rs_E))      w_fwd_a_e = FWD_MEM;
    else if (tag_hit(hz.RegWrite_W, hz.WriteReg_W, hz.Rs_E)) w_fwd_a_e = FWD_WB;
    w_fwd_b_e = FWD_RF;
    if (tag_hit(hz.RegWrite_M, hz.WriteReg_M, hz.Rt_E))      w_fwd_b_e = FWD_MEM;
    else if (tag_hit(hz.RegWrite_W, hz.WriteReg_W, hz.Rt_E)) w_fwd_b_e = FWD_WB;
  end

  always_comb begin
    w_lwstall = hz.MemToReg_E && ((hz.Rt_E == hz.Rs_D) || (hz.Rt_E == hz.Rt_D));
    w_brstall = hz.Branch_D &&
                (tag_hit(hz.RegWrite_E, hz.WriteReg_E, hz.Rs_D) ||
                 tag_hit(hz.RegWrite_E, hz.WriteReg_E, hz.Rt_D) ||
                 tag_hit(hz.MemToReg_M, hz.WriteReg_M, hz.Rs_D) ||
                 tag_hit(hz.MemToReg_M, hz.WriteReg_M, hz.Rt_D));
    w_mdstall = w_md_busy && (hz.MulDiv_D || hz.MfHiLo_D);
    w_stall   = w_lwstall || w_brstall || w_mdstall;
    w_flush_d = hz.PCSrc_D && !w_stall;
  end

  assign hz.Stall_F    = w_stall;
  assign hz.Stall_D    = w_stall;
  assign hz.Flush_E    = w_stall;
  assign hz.Flush_D    = w_flush_d;
  assign hz.ForwardA_E = w_fwd_a_e;
  assign hz.ForwardB_E = w_fwd_b_e;
  assign hz.ForwardA_D = tag_hit(hz.RegWrite_M, hz.WriteReg_M, hz.Rs_D);
  assign hz.ForwardB_D = tag_hit(hz.RegWrite_M, hz.WriteReg_M, hz.Rt_D);
  assign hz.MdBusy     = w_md_busy;

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1))   r_stall_cnt <= r_stall_cnt + STAT_W'(1);
      if (w_flush_d && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + STAT_W'(1);
    end
  end

  assign hz.StallCnt = r_stall_cnt;
  assign hz.FlushCnt = r_flush_cnt;
`else
  assign hz.StallCnt = '0;
  assign hz.FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit (MD_LATENCY=4); stats checks follow HAZARD_STATS_EN.
module tb_hazard_unit;

  logic clk;
  logic rst_n;

  hazard_unit_if #(.STAT_W(16)) hz();

  hazard_unit #(.MD_LATENCY(4), .STAT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

`ifdef HAZARD_STATS_EN
  // Narrow-counter copy driven by the same pipeline signals, for saturation.
  hazard_unit_if #(.STAT_W(2)) hz2();

  assign hz2.Rs_D = hz.Rs_D;             assign hz2.Rt_D = hz.Rt_D;
  assign hz2.Rs_E = hz.Rs_E;             assign hz2.Rt_E = hz.Rt_E;
  assign hz2.WriteReg_E = hz.WriteReg_E; assign hz2.WriteReg_M = hz.WriteReg_M;
  assign hz2.WriteReg_W = hz.WriteReg_W; assign hz2.RegWrite_E = hz.RegWrite_E;
  assign hz2.MemToReg_E = hz.MemToReg_E; assign hz2.RegWrite_M = hz.RegWrite_M;
  assign hz2.MemToReg_M = hz.MemToReg_M; assign hz2.RegWrite_W = hz.RegWrite_W;
  assign hz2.Branch_D = hz.Branch_D;     assign hz2.PCSrc_D = hz.PCSrc_D;
  assign hz2.MulDiv_D = hz.MulDiv_D;     assign hz2.MfHiLo_D = hz.MfHiLo_D;
  assign hz2.MulDivStart_E = hz.MulDivStart_E;

  hazard_unit #(.MD_LATENCY(4), .STAT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz2)
  );
`endif

  typedef struct {
    string      name;
    logic [10:0] exp;
  } sbEntry_t;

  sbEntry_t sbQ[$];
  int       checks;
  int       errors;
  logic     expBusy;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clearInputs();
    hz.Rs_D = 5'd0; hz.Rt_D = 5'd0; hz.Rs_E = 5'd0; hz.Rt_E = 5'd0;
    hz.WriteReg_E = 5'd0; hz.WriteReg_M = 5'd0; hz.WriteReg_W = 5'd0;
    hz.RegWrite_E = 1'b0; hz.MemToReg_E = 1'b0;
    hz.RegWrite_M = 1'b0; hz.MemToReg_M = 1'b0; hz.RegWrite_W = 1'b0;
    hz.Branch_D = 1'b0; hz.PCSrc_D = 1'b0;
    hz.MulDiv_D = 1'b0; hz.MfHiLo_D = 1'b0; hz.MulDivStart_E = 1'b0;
  endtask

  // Reference behaviour of the combinational outputs, given the expected busy flag.
  function automatic logic [10:0] model(input logic busy);
    logic       lw, br, md, st, fad, fbd;
    logic [1:0] fae, fbe;
    fae = (hz.RegWrite_M && hz.WriteReg_M != 5'd0 && hz.WriteReg_M == hz.Rs_E) ? 2'b10 :
          (hz.RegWrite_W && hz.WriteReg_W != 5'd0 && hz.WriteReg_W == hz.Rs_E) ? 2'b01 : 2'b00;
    fbe = (hz.RegWrite_M && hz.WriteReg_M != 5'd0 && hz.WriteReg_M == hz.Rt_E) ? 2'b10 :
          (hz.RegWrite_W && hz.WriteReg_W != 5'd0 && hz.WriteReg_W == hz.Rt_E) ? 2'b01 : 2'b00;
    fad = hz.RegWrite_M && hz.WriteReg_M != 5'd0 && hz.WriteReg_M == hz.Rs_D;
    fbd = hz.RegWrite_M && hz.WriteReg_M != 5'd0 && hz.WriteReg_M == hz.Rt_D;
    lw  = hz.MemToReg_E && (hz.Rt_E == hz.Rs_D || hz.Rt_E == hz.Rt_D);
    br  = hz.Branch_D &&
          ((hz.RegWrite_E && hz.WriteReg_E != 5'd0 &&
            (hz.WriteReg_E == hz.Rs_D || hz.WriteReg_E == hz.Rt_D)) ||
           (hz.MemToReg_M && hz.WriteReg_M != 5'd0 &&
            (hz.WriteReg_M == hz.Rs_D || hz.WriteReg_M == hz.Rt_D)));
    md  = busy && (hz.MulDiv_D || hz.MfHiLo_D);
    st  = lw || br || md;
    return {st, st, hz.PCSrc_D && !st, st, fad, fbd, fae, fbe, busy};
  endfunction

  function automatic logic [10:0] observed();
    return {hz.Stall_F, hz.Stall_D, hz.Flush_D, hz.Flush_E, hz.ForwardA_D, hz.ForwardB_D,
            hz.ForwardA_E, hz.ForwardB_E, hz.MdBusy};
  endfunction

  task automatic applyStimulus(input string name);
    sbEntry_t e;
    e.name = name;
    e.exp  = model(expBusy);
    sbQ.push_back(e);
  endtask

  task automatic test_reset();
    sbEntry_t e;
    logic [10:0] obs;
    clearInputs();
    rst_n   = 1'b0;
    expBusy = 1'b0;
    for (int s = 0; s < 2; s++) begin
      case (s)
        0: ;
        1: begin hz.RegWrite_M = 1'b1; hz.WriteReg_M = 5'd8; hz.Rs_E = 5'd8; end
        default: ;
      endcase
      applyStimulus($sformatf("reset_s%0d", s));
      #2;
      e = sbQ.pop_front();
      obs = observed();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s observed=%b expected=%b", e.name, obs, e.exp);
      end
      @(negedge clk);
    end
    checks++;
    if (hz.StallCnt !== 16'd0 || hz.FlushCnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_counters observed=%0d/%0d expected=0/0", hz.StallCnt, hz.FlushCnt);
    end
    rst_n = 1'b1;
    clearInputs();
    @(negedge clk);
  endtask

  task automatic test_forwarding();
    sbEntry_t e;
    logic [10:0] obs;
    expBusy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      clearInputs();
      case (s)
        0: begin
          hz.RegWrite_M = 1'b1; hz.WriteReg_M = 5'd8; hz.Rs_E = 5'd8;
          hz.RegWrite_W = 1'b1; hz.WriteReg_W = 5'd8; hz.Rt_E = 5'd8;
        end
        1: begin hz.RegWrite_W = 1'b1; hz.WriteReg_W = 5'd8; hz.Rs_E = 5'd8; hz.Rt_E = 5'd3; end
        2: begin
          hz.RegWrite_M = 1'b1; hz.RegWrite_W = 1'b1;
          hz.WriteReg_M = 5'd0; hz.WriteReg_W = 5'd0;
        end
        3: begin hz.RegWrite_M = 1'b1; hz.WriteReg_M = 5'd12; hz.Rs_D = 5'd12; hz.Rt_E = 5'd12; end
        4: begin hz.RegWrite_M = 1'b1; hz.WriteReg_M = 5'd7; hz.Rt_D = 5'd7; hz.RegWrite_W = 1'b1;
                 hz.WriteReg_W = 5'd6; hz.Rt_E = 5'd6; end
        default: ;
      endcase
      applyStimulus($sformatf("fwd_s%0d", s));
      #2;
      e = sbQ.pop_front();
      obs = observed();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s observed=%b expected=%b", e.name, obs, e.exp);
      end
      if (s == 0) begin
        checks++;
        if (hz.ForwardA_E !== 2'b10) begin
          errors++;
          $display("[TB] FAIL fwd_mem_beats_wb observed=%b expected=10", hz.ForwardA_E);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    sbEntry_t e;
    logic [10:0] obs;
    expBusy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      clearInputs();
      case (s)
        0: begin hz.MemToReg_E = 1'b1; hz.Rt_E = 5'd9; hz.Rs_D = 5'd9; end
        1: begin hz.Rs_D = 5'd9; end
        2: begin hz.MemToReg_E = 1'b1; hz.Rt_E = 5'd4; hz.Rt_D = 5'd4; hz.Rs_D = 5'd1; end
        3: begin hz.MemToReg_E = 1'b1; hz.Rt_E = 5'd4; hz.Rs_D = 5'd1; hz.Rt_D = 5'd2; end
        default: ;
      endcase
      applyStimulus($sformatf("lwstall_s%0d", s));
      #2;
      e = sbQ.pop_front();
      obs = observed();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s observed=%b expected=%b", e.name, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    sbEntry_t e;
    logic [10:0] obs;
    expBusy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      clearInputs();
      hz.Branch_D = 1'b1;
      hz.PCSrc_D  = 1'b1;
      case (s)
        0: begin hz.Rs_D = 5'd10; hz.RegWrite_E = 1'b1; hz.WriteReg_E = 5'd10; end
        1: begin hz.Rs_D = 5'd10; hz.RegWrite_M = 1'b1; hz.WriteReg_M = 5'd10; end
        2: begin hz.Rt_D = 5'd11; hz.Rs_D = 5'd1; hz.MemToReg_M = 1'b1; hz.WriteReg_M = 5'd11; end
        3: begin hz.RegWrite_E = 1'b1; hz.WriteReg_E = 5'd0; hz.MemToReg_M = 1'b1; end
        default: ;
      endcase
      applyStimulus($sformatf("branch_s%0d", s));
      #2;
      e = sbQ.pop_front();
      obs = observed();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s observed=%b expected=%b", e.name, obs, e.exp);
      end
      @(negedge clk);
    end
    clearInputs();
  endtask

  task automatic test_muldiv();
    sbEntry_t e;
    logic [10:0] obs;
    for (int s = 0; s < 7; s++) begin
      clearInputs();
      case (s)
        0:       begin hz.MulDivStart_E = 1'b1; expBusy = 1'b0; end
        1, 2, 3: begin hz.MfHiLo_D = 1'b1; expBusy = 1'b1; end
        4:       begin hz.MulDiv_D = 1'b1; expBusy = 1'b1; end
        5:       begin hz.MfHiLo_D = 1'b1; expBusy = 1'b0; end
        default: expBusy = 1'b0;
      endcase
      applyStimulus($sformatf("muldiv_s%0d", s));
      #2;
      e = sbQ.pop_front();
      obs = observed();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s observed=%b expected=%b", e.name, obs, e.exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_busy();
    sbEntry_t e;
    logic [10:0] obs;
    for (int s = 0; s < 9; s++) begin
      clearInputs();
      case (s)
        0:             begin hz.MulDivStart_E = 1'b1; expBusy = 1'b0; end
        1, 2:          begin hz.MfHiLo_D = 1'b1; expBusy = 1'b1; end
        3:             begin rst_n = 1'b1; hz.MulDivStart_E = 1'b1; expBusy = 1'b0; end
        4, 5, 6, 7:    begin hz.MfHiLo_D = 1'b1; expBusy = 1'b1; end
        default:       begin hz.MfHiLo_D = 1'b1; expBusy = 1'b0; end
      endcase
      applyStimulus($sformatf("mdreset_s%0d", s));
      #2;
      e = sbQ.pop_front();
      obs = observed();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("[TB] FAIL %s observed=%b expected=%b", e.name, obs, e.exp);
      end
      if (s == 2) begin
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (hz.MdBusy !== 1'b0 || hz.Stall_D !== 1'b0) begin
          errors++;
          $display("[TB] FAIL mdreset_async observed=%b/%b expected=0/0", hz.MdBusy, hz.Stall_D);
        end
      end
      @(negedge clk);
    end
    clearInputs();
    expBusy = 1'b0;
  endtask

  task automatic test_stats();
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    clearInputs();
    @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      clearInputs();
      if (s < 3) begin
        hz.MemToReg_E = 1'b1; hz.Rt_E = 5'd9; hz.Rs_D = 5'd9;
      end else if (s < 5) begin
        hz.PCSrc_D = 1'b1;
      end
      @(negedge clk);
    end
    #2;
`ifdef HAZARD_STATS_EN
    checks++;
    if (hz.StallCnt !== 16'd3 || hz.FlushCnt !== 16'd2) begin
      errors++;
      $display("[TB] FAIL stats_counts observed=%0d/%0d expected=3/2", hz.StallCnt, hz.FlushCnt);
    end
`else
    checks++;
    if (hz.StallCnt !== 16'd0 || hz.FlushCnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stats_disabled observed=%0d/%0d expected=0/0", hz.StallCnt, hz.FlushCnt);
    end
`endif
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      clearInputs();
      if (s < 2) begin
        hz.MemToReg_E = 1'b1; hz.Rt_E = 5'd5; hz.Rt_D = 5'd5;
      end
      @(negedge clk);
    end
    #2;
`ifdef HAZARD_STATS_EN
    checks++;
    if (hz.StallCnt !== 16'd5 || hz2.StallCnt !== 2'd3 || hz2.FlushCnt !== 2'd2) begin
      errors++;
      $display("[TB] FAIL stats_saturate observed=%0d/%0d/%0d expected=5/3/2",
               hz.StallCnt, hz2.StallCnt, hz2.FlushCnt);
    end
`else
    checks++;
    if (hz.StallCnt !== 16'd0) begin
      errors++;
      $display("[TB] FAIL stats_disabled_more observed=%0d expected=0", hz.StallCnt);
    end
`endif
    @(negedge clk);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    expBusy = 1'b0;
    rst_n   = 1'b0;
    clearInputs();
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_muldiv();
    test_reset_mid_busy();
    test_stats();
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d expected=0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
